// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP32 constants, flag bit indices and the post-multiply stage-1 register type
package fpu_pkg;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [9:0] FP32_BIAS = 10'd127;
  localparam logic signed [10:0] FP32_EXP_MAX = 11'sd255;
  localparam int FLG_INEXACT = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW = 2;
  localparam int FLG_INVALID = 3;
  typedef enum logic [1:0] {CLS_FIN, CLS_NAN, CLS_INF, CLS_ZERO} cls_e;
  typedef struct packed {
    logic sign;
    logic signed [10:0] e;
    logic [23:0] keep;
    logic guard;
    logic sticky;
    logic tiny;
    logic invalid;
    cls_e cls;
  } s1_t;
endpackage

// File: rtl/fpu_mul_round_if.sv
// fpu_mul_round_if: product-in / packed-result-out handshake bundle
interface fpu_mul_round_if;
  logic in_valid;
  logic in_ready;
  logic in_sign;
  logic [9:0] in_exp;
  logic [47:0] in_mant;
  logic in_snan;
  logic in_qnan;
  logic in_invalid;
  logic in_inf;
  logic in_zero;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_res;
  logic [3:0] out_flags;
  modport slave (
    input in_valid, in_sign, in_exp, in_mant, in_snan, in_qnan, in_invalid, in_inf, in_zero, out_ready,
    output in_ready, out_valid, out_res, out_flags
  );
  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_snan, in_qnan, in_invalid, in_inf, in_zero, out_ready,
    input in_ready, out_valid, out_res, out_flags
  );
endinterface

// File: rtl/fpu_round_rne.sv
// fpu_round_rne: round-to-nearest-even of a 24-bit significand with guard/sticky
module fpu_round_rne (
  input logic [23:0] keep,
  input logic guard,
  input logic sticky,
  input logic signed [10:0] exp_in,
  output logic [23:0] sig,
  output logic signed [10:0] exp_out,
  output logic carry,
  output logic inexact
);
  logic [24:0] sum;
  // bump on above-half or odd tie; a carry renormalizes to 1.0, a subnormal reaching bit 23 becomes normal
  always_comb begin
    sum = {1'b0, keep} + {24'd0, guard && (sticky || keep[0])};
    carry = sum[24];
    sig = carry ? 24'h80_0000 : sum[23:0];
    exp_out = carry ? exp_in + 11'sd1 : (exp_in == 11'sd0 && sum[23]) ? 11'sd1 : exp_in;
    inexact = guard || sticky;
  end
endmodule

// File: rtl/fpu_mul_round.sv
// fpu_mul_round: two-stage normalize/round/pack of the FP32 product; FPU_SUBNORMAL_EN enables gradual underflow
module fpu_mul_round
  import fpu_pkg::*;
(
  input logic clk,
  input logic rst,
  fpu_mul_round_if.slave bus
);
  s1_t s1_d, s1_q;
  logic s1_valid, s1_adv;
  logic [47:0] n;
  logic signed [10:0] e_n;
`ifdef FPU_SUBNORMAL_EN
  logic [10:0] sh_raw;
  logic [4:0] sh;
  logic [51:0] wide;
`endif
  logic [23:0] sig;
  logic signed [10:0] exp_r;
  logic carry, inexact, sig_unused, ovf, tiny_zero;
  logic [31:0] fin_res, res_d;
  logic [3:0] fin_flags, flags_d;
  assign s1_adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_adv;
  // normalize the product to [1,2), split keep/guard/sticky, classify, denormalize tiny values
  always_comb begin
    n = bus.in_mant[47] ? bus.in_mant : {bus.in_mant[46:0], 1'b0};
    e_n = {bus.in_exp[9], bus.in_exp} + {10'd0, bus.in_mant[47]};
    s1_d.sign = bus.in_sign;
    s1_d.e = e_n;
    s1_d.keep = n[47:24];
    s1_d.guard = n[23];
    s1_d.sticky = |n[22:0];
    s1_d.tiny = e_n < 11'sd1;
    s1_d.invalid = bus.in_snan || bus.in_invalid;
    s1_d.cls = (bus.in_snan || bus.in_qnan || bus.in_invalid) ? CLS_NAN : bus.in_inf ? CLS_INF : bus.in_zero ? CLS_ZERO : CLS_FIN;
`ifdef FPU_SUBNORMAL_EN
    sh_raw = 11'd1 - e_n;
    sh = (sh_raw > 11'd26) ? 5'd26 : sh_raw[4:0];
    wide = {n[47:24], n[23], |n[22:0], 26'd0} >> sh;
    if (s1_d.tiny) begin
      s1_d.e = '0;
      s1_d.keep = wide[51:28];
      s1_d.guard = wide[27];
      s1_d.sticky = wide[26] || (|wide[25:0]);
    end
`endif
  end
  fpu_round_rne u_rnd (
    .keep(s1_q.keep),
    .guard(s1_q.guard),
    .sticky(s1_q.sticky),
    .exp_in(s1_q.e),
    .sig(sig),
    .exp_out(exp_r),
    .carry(carry),
    .inexact(inexact)
  );
  assign sig_unused = sig[23];
  // round, catch overflow before or after rounding, flush tiny values when gradual underflow is off, then specials win
  always_comb begin
`ifdef FPU_SUBNORMAL_EN
    tiny_zero = 1'b0;
`else
    tiny_zero = s1_q.tiny;
`endif
    ovf = ($signed(s1_q.e) >= FP32_EXP_MAX) || (carry && exp_r >= FP32_EXP_MAX);
    fin_res = tiny_zero ? {s1_q.sign, 31'd0} : ovf ? {s1_q.sign, 8'hFF, 23'd0} : {s1_q.sign, exp_r[7:0], sig[22:0]};
    fin_flags = '0;
    fin_flags[FLG_OVERFLOW] = ovf;
    fin_flags[FLG_UNDERFLOW] = s1_q.tiny && (inexact || tiny_zero);
    fin_flags[FLG_INEXACT] = ovf || inexact || tiny_zero;
    res_d = s1_q.cls == CLS_NAN ? FP32_QNAN : s1_q.cls == CLS_INF ? {s1_q.sign, 8'hFF, 23'd0} : s1_q.cls == CLS_ZERO ? {s1_q.sign, 31'd0} : fin_res;
    flags_d = '0;
    flags_d[FLG_INVALID] = s1_q.cls == CLS_NAN && s1_q.invalid;
    if (s1_q.cls == CLS_FIN) flags_d = fin_flags;
  end
  // stage 1 register loads whenever it is empty or draining into stage 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_q <= s1_d;
    end
  end
  // stage 2 output register holds the packed result stable while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_res <= '0;
      bus.out_flags <= '0;
    end else if (s1_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_res <= res_d;
        bus.out_flags <= flags_d;
      end
    end
  end
endmodule
